// File: rtl/spi_byte_feeder.sv
// spi_byte_feeder: streaming front end for a single-shot SPI master.
// TX bytes are queued and issued one at a time through the master's
// din/start handshake. Each received byte goes into an RX FIFO that the
// host reads with first-word fall-through.
module spi_byte_feeder #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DATA_W-1:0]        spi_din_o,
  output logic                     spi_start_o,
  input  logic                     spi_ready_i,
  input  logic                     spi_done_tick_i,
  input  logic [DATA_W-1:0]        spi_dout_i,
  output logic [$clog2(DEPTH):0]   tx_level_o,
  output logic                     busy_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_done_ok, rx_drop;
  // set when a flush lands while a byte is on the wire; that byte's echo is thrown away
  logic discard;

  // extra pointer MSB separates full from empty
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  // full blocks a push even when a pop happens in the same cycle
  assign tx_push    = wr_valid_i && !tx_full && !clr_i;
  assign tx_pop     = (state == IDLE) && !tx_empty && spi_ready_i && !clr_i;
  assign rx_pop     = rd_valid_o && rd_ready_i;
  assign rx_done_ok = (state == WAIT_DONE) && spi_done_tick_i && !discard && !clr_i;
  assign rx_push    = rx_done_ok && (!rx_full || rx_pop);
  assign rx_drop    = rx_done_ok && rx_full && !rx_pop;

  assign wr_ready_o = !tx_full;
  assign rd_valid_o = !rx_empty;
  assign rd_data_o  = rx_empty ? '0 : rx_mem[rx_rptr[AW-1:0]];
  assign tx_level_o = tx_wptr - tx_rptr;
  assign busy_o     = (state != IDLE);

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wr_data_i;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= spi_dout_i;
  end

  // TX/RX pointers; flush wins over any same-cycle push or pop
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else if (clr_i) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // sticky overflow and discard-on-flush bookkeeping
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow_o <= 1'b0;
      discard    <= 1'b0;
    end else begin
      if (clr_i)        overflow_o <= 1'b0;
      else if (rx_drop) overflow_o <= 1'b1;
      if ((state == WAIT_DONE) && spi_done_tick_i) discard <= 1'b0;
      else if (clr_i && (state != IDLE))            discard <= 1'b1;
    end
  end

  // transfer sequencer: issue head, pulse start for one cycle, wait for done
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      spi_start_o <= 1'b0;
      spi_din_o   <= '0;
    end else begin
      spi_start_o <= 1'b0;
      case (state)
        IDLE: if (tx_pop) begin
          spi_din_o   <= tx_mem[tx_rptr[AW-1:0]];
          spi_start_o <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE:     state <= WAIT_DONE;
        WAIT_DONE: if (spi_done_tick_i) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_byte_feeder.sv
// Bench for spi_byte_feeder: a small SPI master model echoes din ^ echo_key,
// scoreboard queues hold the expected start order and expected RX bytes.
module tb_spi_byte_feeder;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic [DW-1:0] spi_din_o;
  logic          spi_start_o;
  logic          spi_ready_i = 1'b0;
  logic          spi_done_tick_i = 1'b0;
  logic [DW-1:0] spi_dout_i = '0;
  logic [3:0]    tx_level_o;
  logic          busy_o;
  logic          overflow_o;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] echo_key = '0;
  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] exp_rx[$];

  spi_byte_feeder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .spi_din_o(spi_din_o), .spi_start_o(spi_start_o), .spi_ready_i(spi_ready_i),
    .spi_done_tick_i(spi_done_tick_i), .spi_dout_i(spi_dout_i),
    .tx_level_o(tx_level_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // host write; expected RX echo goes to the scoreboard unless it will be dropped
  task automatic push_byte(input logic [DW-1:0] b, input bit expect_rx);
    int n = 0;
    while (!wr_ready_o && n < 60) begin tick; n++; end
    vectors++;
    if (wr_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL push_wait wr_ready=%0b required 1", wr_ready_o);
    end
    wr_data_i = b; wr_valid_i = 1'b1;
    tick;
    wr_valid_i = 1'b0;
    exp_tx.push_back(b);
    if (expect_rx) exp_rx.push_back(b ^ echo_key);
  endtask

  // SPI master model: wait for start, check din order, answer with a done tick
  task automatic serve_one(input bit pop_on_done);
    int n = 0;
    logic [DW-1:0] d, e;
    while (!spi_start_o && n < 60) begin tick; n++; end
    vectors++;
    if (spi_start_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_timeout spi_start=%0b required 1", spi_start_o);
    end else begin
      e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
      vectors++;
      if (spi_din_o !== e) begin
        miscompares++;
        $display("FAIL start_din got %02h required %02h", spi_din_o, e);
      end
      d = spi_din_o;
      tick; tick;
      vectors++;
      if ({spi_start_o, busy_o} !== 2'b01) begin
        miscompares++;
        $display("FAIL wait_done start/busy got %02b required 01", {spi_start_o, busy_o});
      end
      spi_done_tick_i = 1'b1; spi_dout_i = d ^ echo_key;
      if (pop_on_done) begin
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
        vectors++;
        if (rd_data_o !== e) begin
          miscompares++;
          $display("FAIL pop_on_done rd_data got %02h required %02h", rd_data_o, e);
        end
        rd_ready_i = 1'b1;
      end
      tick;
      spi_done_tick_i = 1'b0; rd_ready_i = 1'b0;
    end
  endtask

  // pop everything in RX and compare against the scoreboard
  task automatic drain_rx;
    int n = 0;
    logic [DW-1:0] e;
    while (rd_valid_o && n < DEPTH + 2) begin
      e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      vectors++;
      if (rd_data_o !== e) begin
        miscompares++;
        $display("FAIL rx_data got %02h required %02h", rd_data_o, e);
      end
      rd_ready_i = 1'b1;
      tick;
      rd_ready_i = 1'b0;
      n++;
    end
    vectors++;
    if (exp_rx.size() != 0 || rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_drain left=%0d rd_valid=%0b required 0/0", exp_rx.size(), rd_valid_o);
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({spi_start_o, busy_o, overflow_o, rd_valid_o, tx_level_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flags got %02h required 00", {spi_start_o, busy_o, overflow_o, rd_valid_o, tx_level_o});
    end
    vectors++;
    if ({spi_din_o, rd_data_o} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data got %04h required 0000", {spi_din_o, rd_data_o});
    end
    reset_i = 1'b1;
    tick;
    vectors++;
    if (wr_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wr_ready got %0b required 1", wr_ready_o);
    end
  endtask

  task automatic test_single;
    echo_key = 8'h99;   // A5 -> 3C
    spi_ready_i = 1'b1;
    wr_data_i = 8'hA5; wr_valid_i = 1'b1;
    tick;               // edge N: accepted
    wr_valid_i = 1'b0;
    exp_rx.push_back(8'hA5 ^ echo_key);
    vectors++;
    if ({spi_start_o, tx_level_o} !== 5'b0_0001) begin
      miscompares++;
      $display("FAIL single_n start/level got %05b required 00001", {spi_start_o, tx_level_o});
    end
    tick;               // edge N+1: ISSUE
    vectors++;
    if ({spi_start_o, busy_o, spi_din_o, tx_level_o} !== {2'b11, 8'hA5, 4'd0}) begin
      miscompares++;
      $display("FAIL single_issue got %0b%0b %02h %0d required 11 a5 0", spi_start_o, busy_o, spi_din_o, tx_level_o);
    end
    tick;               // edge N+2: start drops, din held
    vectors++;
    if ({spi_start_o, busy_o, spi_din_o} !== {2'b01, 8'hA5}) begin
      miscompares++;
      $display("FAIL single_pulse got %0b%0b %02h required 01 a5", spi_start_o, busy_o, spi_din_o);
    end
    spi_done_tick_i = 1'b1; spi_dout_i = 8'h3C;
    tick;
    spi_done_tick_i = 1'b0;
    vectors++;
    if ({rd_valid_o, busy_o, rd_data_o} !== {2'b10, 8'h3C}) begin
      miscompares++;
      $display("FAIL single_rx got %0b%0b %02h required 10 3c", rd_valid_o, busy_o, rd_data_o);
    end
    drain_rx();
  endtask

  task automatic test_burst;
    echo_key = 8'h00;
    spi_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(DW'(i), 1'b1);
    vectors++;
    if ({wr_ready_o, tx_level_o} !== 5'b0_1000) begin
      miscompares++;
      $display("FAIL burst_full ready/level got %0b %0d required 0 8", wr_ready_o, tx_level_o);
    end
    wr_data_i = 8'hFF; wr_valid_i = 1'b1;   // must be refused
    tick;
    wr_valid_i = 1'b0;
    vectors++;
    if (tx_level_o !== 4'd8) begin
      miscompares++;
      $display("FAIL burst_refuse level got %0d required 8", tx_level_o);
    end
    spi_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) serve_one(1'b0);
    vectors++;
    if ({wr_ready_o, rd_valid_o, overflow_o, tx_level_o} !== 7'b110_0000) begin
      miscompares++;
      $display("FAIL burst_end got %07b required 1100000", {wr_ready_o, rd_valid_o, overflow_o, tx_level_o});
    end
    drain_rx();
  endtask

  task automatic test_ready_gating;
    bit seen = 1'b0;
    echo_key = 8'h0F;
    spi_ready_i = 1'b0;
    push_byte(8'h55, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (spi_start_o) seen = 1'b1;
      tick;
    end
    vectors++;
    if ({seen, busy_o, tx_level_o} !== 6'b00_0001) begin
      miscompares++;
      $display("FAIL gated start/busy/level got %0b%0b %0d required 00 1", seen, busy_o, tx_level_o);
    end
    spi_done_tick_i = 1'b1; spi_dout_i = 8'hEE;  // spurious tick in IDLE
    tick;
    spi_done_tick_i = 1'b0;
    vectors++;
    if (rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_done rd_valid got %0b required 0", rd_valid_o);
    end
    spi_ready_i = 1'b1;
    tick;
    vectors++;
    if (spi_start_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ungate_start got %0b required 1", spi_start_o);
    end
    serve_one(1'b0);
    drain_rx();
  endtask

  task automatic test_overflow;
    echo_key = 8'h30;
    spi_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h40 + DW'(i), i < 8);
      serve_one(1'b0);
    end
    vectors++;
    if ({overflow_o, rd_valid_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL overflow_set ovf/valid got %0b%0b required 11", overflow_o, rd_valid_o);
    end
    drain_rx();
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky got %0b required 1", overflow_o);
    end
    clr_i = 1'b1;
    tick;
    clr_i = 1'b0;
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clr got %0b required 0", overflow_o);
    end
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h60 + DW'(i), 1'b1);
      serve_one(i == 8);
    end
    vectors++;
    if ({overflow_o, rd_valid_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL full_pop_push ovf/valid got %0b%0b required 01", overflow_o, rd_valid_o);
    end
    drain_rx();
  endtask

  task automatic test_clr;
    bit seen = 1'b0;
    echo_key = 8'h5A;
    spi_ready_i = 1'b1;
    push_byte(8'h11, 1'b1);
    serve_one(1'b0);                 // RX now holds one byte
    spi_ready_i = 1'b0;
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    push_byte(8'h55, 1'b0);
    spi_ready_i = 1'b1;
    tick;
    vectors++;
    if ({spi_start_o, spi_din_o} !== {1'b1, 8'h22}) begin
      miscompares++;
      $display("FAIL clr_issue got %0b %02h required 1 22", spi_start_o, spi_din_o);
    end
    tick;                            // WAIT_DONE, 3 queued
    vectors++;
    if ({tx_level_o, rd_valid_o} !== 5'b0011_1) begin
      miscompares++;
      $display("FAIL clr_pre level/valid got %0d %0b required 3 1", tx_level_o, rd_valid_o);
    end
    clr_i = 1'b1;
    tick;
    clr_i = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    vectors++;
    if ({tx_level_o, rd_valid_o, busy_o} !== 6'b0000_01) begin
      miscompares++;
      $display("FAIL clr_post level/valid/busy got %0d %0b %0b required 0 0 1", tx_level_o, rd_valid_o, busy_o);
    end
    spi_done_tick_i = 1'b1; spi_dout_i = 8'h22 ^ echo_key;
    tick;
    spi_done_tick_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (spi_start_o) seen = 1'b1;
      tick;
    end
    vectors++;
    if ({rd_valid_o, busy_o, seen} !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_discard valid/busy/start got %03b required 000", {rd_valid_o, busy_o, seen});
    end
    push_byte(8'h77, 1'b1);          // next transfer lands normally
    serve_one(1'b0);
    drain_rx();
  endtask

  task automatic test_async_reset;
    echo_key = 8'h00;
    spi_ready_i = 1'b1;
    push_byte(8'h80, 1'b1);
    serve_one(1'b0);                 // RX holds one byte
    push_byte(8'h81, 1'b1);
    push_byte(8'h82, 1'b1);          // 81 issued, 82 queued
    tick;                            // WAIT_DONE
    #3 reset_i = 1'b0;
    #1;
    vectors++;
    if ({spi_start_o, busy_o, rd_valid_o, overflow_o, tx_level_o, spi_din_o, rd_data_o} !== 24'h0) begin
      miscompares++;
      $display("FAIL async_reset got %0b%0b%0b%0b %0d %02h %02h required 0000 0 00 00",
               spi_start_o, busy_o, rd_valid_o, overflow_o, tx_level_o, spi_din_o, rd_data_o);
    end
    #3 reset_i = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    tick;
    tick;
    vectors++;
    if ({wr_ready_o, busy_o, rd_valid_o, spi_start_o, tx_level_o} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL post_reset got %08b required 10000000", {wr_ready_o, busy_o, rd_valid_o, spi_start_o, tx_level_o});
    end
    push_byte(8'h90, 1'b1);
    serve_one(1'b0);
    drain_rx();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_ready_gating();
    test_overflow();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim time expired, required bench completion");
    $fatal(1, "watchdog");
  end
endmodule
